// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: RV32M DIV/DIVU/REM/REMU sequencer, radix-2 restoring
// shift-subtract, XLEN+2 cycle latency, 1 cycle for /0 and overflow.
// Ports: clk_i, rst_ni (sync, active-low), start_i, op_i, rs1_i, rs2_i,
//   flush_i -> stall_o, busy_o, valid_o, result_o.
// Optional macro DIV_RESULT_REUSE_EN: reuse last operands' results.
module div_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;

  logic            is_signed;
  logic            accept;
  logic            div_zero;
  logic            ovf;
  logic            hit;
  logic            fast;
  logic            calc_last;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] st_quo;
  logic [XLEN-1:0] st_rem;
  logic [XLEN:0]   shl;
  logic [XLEN:0]   diff;

  assign is_signed = ~op_i[0];
  assign accept    = (state_q == IDLE)
                   & start_i & ~flush_i;
  assign div_zero  = (rs2_i == '0);
  assign ovf       = is_signed
                   & (rs1_i == MIN_NEG)
                   & (rs2_i == '1);
  assign fast      = div_zero | ovf | hit;
  assign calc_last = (cnt_q == '0);

  // Magnitudes; -MIN_NEG wraps to MIN_NEG,
  // which is the right unsigned magnitude.
  assign abs1 = (is_signed & rs1_i[XLEN-1])
              ? -rs1_i : rs1_i;
  assign abs2 = (is_signed & rs2_i[XLEN-1])
              ? -rs2_i : rs2_i;

  // Partial remainder with next dividend bit
  // shifted in, then trial subtract.
  assign shl  = {rem_q, quo_q[XLEN-1]};
  assign diff = shl - {1'b0, dvs_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = fast ? DONE : CALC;
          end
        end
        CALC: begin
          if (calc_last) begin
            state_d = FIX;
          end
        end
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o  = 1'b0;
    busy_o   = (state_q != IDLE);
    valid_o  = 1'b0;
    result_o = '0;
    unique case (state_q)
      IDLE: stall_o = start_i & ~flush_i;
      CALC: stall_o = ~flush_i;
      FIX:  stall_o = ~flush_i;
      DONE: begin
        if (!flush_i) begin
          valid_o  = 1'b1;
          result_o = op_q[1] ? rem_q : quo_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
    end else if (accept) begin
      op_q      <= op_i;
      cnt_q     <= CW'(XLEN-1);
      neg_quo_q <= is_signed
                 & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
      neg_rem_q <= is_signed & rs1_i[XLEN-1];
      dvs_q     <= abs2;
      if (hit) begin
        quo_q <= st_quo;
        rem_q <= st_rem;
      end else if (div_zero) begin
        quo_q <= '1;
        rem_q <= rs1_i;
      end else if (ovf) begin
        quo_q <= MIN_NEG;
        rem_q <= '0;
      end else begin
        quo_q <= abs1;
        rem_q <= '0;
      end
    end else if (state_q == CALC) begin
      if (!calc_last) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shl[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end else if (state_q == FIX) begin
      if (neg_quo_q) begin
        quo_q <= -quo_q;
      end
      if (neg_rem_q) begin
        rem_q <= -rem_q;
      end
    end
  end

`ifdef DIV_RESULT_REUSE_EN
  logic            st_vld;
  logic            st_uns;
  logic [XLEN-1:0] st_rs1;
  logic [XLEN-1:0] st_rs2;
  logic            uns_q;
  logic [XLEN-1:0] raw1_q;
  logic [XLEN-1:0] raw2_q;

  assign hit = st_vld
             & (rs1_i == st_rs1)
             & (rs2_i == st_rs2)
             & (op_i[0] == st_uns);

  // Store is written only when DONE is not
  // killed, so a flushed op never lands here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_vld <= 1'b0;
      st_uns <= 1'b0;
      st_rs1 <= '0;
      st_rs2 <= '0;
      st_quo <= '0;
      st_rem <= '0;
      uns_q  <= 1'b0;
      raw1_q <= '0;
      raw2_q <= '0;
    end else if (flush_i) begin
      st_vld <= 1'b0;
    end else begin
      if (accept) begin
        uns_q  <= op_i[0];
        raw1_q <= rs1_i;
        raw2_q <= rs2_i;
      end
      if (state_q == DONE) begin
        st_vld <= 1'b1;
        st_uns <= uns_q;
        st_rs1 <= raw1_q;
        st_rs2 <= raw2_q;
        st_quo <= quo_q;
        st_rem <= rem_q;
      end
    end
  end
`else
  assign hit    = 1'b0;
  assign st_quo = '0;
  assign st_rem = '0;
`endif

endmodule
